// File: rtl/wb_dual_arbiter_if.sv
// Wishbone pipelined bus bundle: request fields from master, response fields from slave.
// No storage; pure wiring.
// STALL travels slave->master alongside ACK/ERR.
interface wb_dual_arbiter_if #(
   parameter int AW = 24,
   parameter int DW = 32
);
   logic          cyc;
   logic          stb;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] data;
   logic          ack;
   logic          stall;
   logic          err;

   // Seen from the bus master: drives the request, receives the response.
   modport master (output cyc, stb, we, addr, data, input ack, stall, err);
   // Seen from the bus slave: receives the request, drives the response.
   modport slave  (input cyc, stb, we, addr, data, output ack, stall, err);
endinterface

// File: rtl/wb_dual_arbiter.sv
// Two-master (A=data, priority; B=fetch) to one-slave Wishbone arbiter with bus watchdog.
// Zero added latency: slave request and owner's responses are combinational muxes.
// Non-owner always sees STALL=1; owner sees slave STALL, or STALL=1 while an abort drains.
module wb_dual_arbiter #(
   parameter int AW      = 24,
   parameter int DW      = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   wb_dual_arbiter_if.slave     a,
   wb_dual_arbiter_if.slave     b,
   wb_dual_arbiter_if.master    m
);

   // Counter wide enough to hold TIMEOUT-1; kept at one bit when the watchdog is off.
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] WD_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

   logic          r_owner;     // 1 = master A owns the bus
   logic          r_abort;     // watchdog fired; bus held idle until owner drops CYC
   logic [TW-1:0] r_wdog;      // clocks of active CYC without ACK/ERR

   logic          nxt_owner;
   logic          nxt_abort;
   logic [TW-1:0] nxt_wdog;

   logic          own_cyc;
   logic          own_stb;
   logic          own_we;
   logic [AW-1:0] own_addr;
   logic [DW-1:0] own_data;
   logic          bus_cyc;
   logic          wdog_fire;
   logic          owner_ack;
   logic          owner_err;
   logic          owner_stall;

   // Select the current owner's request and derive the gated slave cycle.
   always_comb begin
      own_cyc  = r_owner ? a.cyc  : b.cyc;
      own_stb  = r_owner ? a.stb  : b.stb;
      own_we   = r_owner ? a.we   : b.we;
      own_addr = r_owner ? a.addr : b.addr;
      own_data = r_owner ? a.data : b.data;
      bus_cyc  = own_cyc & ~r_abort & ~i_rst;
      wdog_fire = 1'b0;
      if (TIMEOUT > 0)
         wdog_fire = bus_cyc & ~m.ack & ~m.err & (r_wdog == WD_LAST);
   end

   // State register: ownership, abort flag and watchdog counter.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_owner <= 1'b1;
         r_abort <= 1'b0;
         r_wdog  <= '0;
      end else begin
         r_owner <= nxt_owner;
         r_abort <= nxt_abort;
         r_wdog  <= nxt_wdog;
      end
   end

   // Next state: ownership only changes while the owner is idle; A wins ties.
   always_comb begin
      nxt_owner = r_owner;
      nxt_abort = 1'b0;
      nxt_wdog  = '0;
      if (!own_cyc) begin
         if (a.cyc)
            nxt_owner = 1'b1;
         else if (b.cyc)
            nxt_owner = 1'b0;
      end
      if (TIMEOUT > 0) begin
         // Counter saturates naturally: firing raises abort, which drops bus_cyc and clears it.
         if (bus_cyc && !m.ack && !m.err)
            nxt_wdog = r_wdog + 1'b1;
         nxt_abort = r_abort;
         if (wdog_fire)
            nxt_abort = 1'b1;
         else if (r_abort && !own_cyc)
            nxt_abort = 1'b0;
      end
   end

   // Outputs: drive slave from owner, route responses to owner only.
   always_comb begin
      m.cyc  = bus_cyc;
      m.stb  = own_stb & bus_cyc;
      m.we   = own_we;
      m.addr = own_addr;
      m.data = own_data;

      owner_ack   = m.ack & bus_cyc;
      owner_err   = (m.err & bus_cyc) | wdog_fire;
      owner_stall = m.stall | r_abort | i_rst;

      a.ack   = r_owner & owner_ack;
      a.err   = r_owner & owner_err;
      a.stall = ~r_owner | owner_stall;
      b.ack   = ~r_owner & owner_ack;
      b.err   = ~r_owner & owner_err;
      b.stall = r_owner | owner_stall;
   end

endmodule
